// File: rtl/irq_timer_ctrl.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp timer plus edge-latched external lines,
// arbitrated into a one-cycle e_inter pulse with trap tracking and post-mret hold-off.
module irq_timer_ctrl #(
   parameter int N_EXT   = 4,
   parameter int HOLDOFF = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       bus_addr,
   input  logic [31:0]      bus_wdata,
   input  logic             bus_we,
   input  logic             bus_re,
   output logic [31:0]      bus_rdata,
   input  logic [N_EXT-1:0] ext_irq,
   input  logic             mret_done,
   input  logic             stall,
   output logic             e_inter,
   output logic [31:0]      irq_cause
);

   typedef enum logic [1:0] {IDLE = 2'd0, FIRE = 2'd1, TRAP = 2'd2, HOLD = 2'd3} state_e;

   localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

   logic [63:0]      mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic [N_EXT-1:0] ext_pend_q, ext_pend_d, ext_prev_q, ext_en_q, ext_en_d;
   logic             tmr_en_q, tmr_en_d;
   logic [31:0]      rdata_q, rdata_d, cause_q;
   logic             e_inter_q;
   state_e           state_q;
   logic [3:0]       hold_q;

   logic             tmr_pend, fire_req;
   logic [N_EXT-1:0] ext_hit, ext_w1c;
   logic [31:0]      pend_word, en_word;

   assign tmr_pend = (mtime_q >= mtimecmp_q);
   assign ext_hit  = ext_pend_q & ext_en_q;
   assign fire_req = ((|ext_hit) | (tmr_pend & tmr_en_q)) & ~stall;
   assign ext_w1c  = (bus_we && bus_addr == 3'd4) ? bus_wdata[N_EXT-1:0] : '0;

   always_comb begin
      pend_word              = '0;
      pend_word[16]          = tmr_pend;
      pend_word[N_EXT-1:0]   = ext_pend_q;
      en_word                = '0;
      en_word[16]            = tmr_en_q;
      en_word[N_EXT-1:0]     = ext_en_q;
   end

   always_comb begin
      mtime_d    = mtime_q + 64'd1;
      mtimecmp_d = mtimecmp_q;
      tmr_en_d   = tmr_en_q;
      ext_en_d   = ext_en_q;
      if (bus_we) begin
         case (bus_addr)
            3'd0: mtime_d          = {mtime_q[63:32], bus_wdata};
            3'd1: mtime_d          = {bus_wdata, mtime_q[31:0]};
            3'd2: mtimecmp_d[31:0]  = bus_wdata;
            3'd3: mtimecmp_d[63:32] = bus_wdata;
            3'd5: begin
               tmr_en_d = bus_wdata[16];
               ext_en_d = bus_wdata[N_EXT-1:0];
            end
            default: ;
         endcase
      end
      // a fresh rising edge beats a same-cycle W1C on the same bit
      ext_pend_d = (ext_pend_q & ~ext_w1c) | (ext_irq & ~ext_prev_q);
      rdata_d    = rdata_q;
      if (bus_re) begin
         case (bus_addr)
            3'd0:    rdata_d = mtime_q[31:0];
            3'd1:    rdata_d = mtime_q[63:32];
            3'd2:    rdata_d = mtimecmp_q[31:0];
            3'd3:    rdata_d = mtimecmp_q[63:32];
            3'd4:    rdata_d = pend_word;
            3'd5:    rdata_d = en_word;
            3'd6:    rdata_d = {30'd0, state_q};
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         ext_pend_q <= '0;
         ext_prev_q <= '0;
         ext_en_q   <= '0;
         tmr_en_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ext_pend_q <= ext_pend_d;
         ext_prev_q <= ext_irq;
         ext_en_q   <= ext_en_d;
         tmr_en_q   <= tmr_en_d;
         rdata_q    <= rdata_d;
      end
   end

   // HOLD lasts max(HOLDOFF,1) cycles before IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         e_inter_q <= 1'b0;
         cause_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (fire_req) begin
               state_q   <= FIRE;
               e_inter_q <= 1'b1;
               cause_q   <= (|ext_hit) ? CAUSE_EXT : CAUSE_TMR;
            end
            FIRE: begin
               e_inter_q <= 1'b0;
               state_q   <= TRAP;
            end
            TRAP: if (mret_done) begin
               state_q <= HOLD;
               hold_q  <= '0;
            end
            HOLD: begin
               if (({1'b0, hold_q} + 5'd1) >= 5'(HOLDOFF)) state_q <= IDLE;
               else                                        hold_q  <= hold_q + 4'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_rdata = rdata_q;
   assign e_inter   = e_inter_q;
   assign irq_cause = cause_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed + randomized bench for irq_timer_ctrl against a cycle-level behavioural model.
module tb_irq_timer_ctrl;
   localparam int N_EXT   = 4;
   localparam int HOLDOFF = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       bus_addr;
   logic [31:0]      bus_wdata;
   logic             bus_we, bus_re;
   logic [31:0]      bus_rdata;
   logic [N_EXT-1:0] ext_irq;
   logic             mret_done, stall;
   logic             e_inter;
   logic [31:0]      irq_cause;

   int tests = 0;
   int fails = 0;

   irq_timer_ctrl #(.N_EXT(N_EXT), .HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .ext_irq(ext_irq),
      .mret_done(mret_done), .stall(stall), .e_inter(e_inter), .irq_cause(irq_cause)
   );

   always #5 clk = ~clk;

   // reference model: state 0 idle, 1 firing, 2 in trap, 3 hold-off
   logic [63:0]      m_time, m_cmp;
   logic [N_EXT-1:0] m_pend, m_prev, m_en_x;
   logic             m_en_t, m_eint;
   logic [31:0]      m_cause, m_rd;
   int               m_st, m_hold;

   task automatic m_reset();
      m_time = '0; m_cmp = '1; m_pend = '0; m_prev = '0; m_en_x = '0; m_en_t = 1'b0;
      m_eint = 1'b0; m_cause = '0; m_rd = '0; m_st = 0; m_hold = 0;
   endtask

   task automatic m_step();
      logic tp, hit_x, hit;
      tp    = (m_time >= m_cmp);
      hit_x = ((m_pend & m_en_x) != '0);
      hit   = hit_x || (tp && m_en_t);
      if (bus_re) begin
         case (bus_addr)
            3'd0: m_rd = m_time[31:0];
            3'd1: m_rd = m_time[63:32];
            3'd2: m_rd = m_cmp[31:0];
            3'd3: m_rd = m_cmp[63:32];
            3'd4: m_rd = {15'd0, tp, 12'd0, m_pend};
            3'd5: m_rd = {15'd0, m_en_t, 12'd0, m_en_x};
            3'd6: m_rd = m_st;
            default: m_rd = 0;
         endcase
      end
      case (m_st)
         0: if (hit && !stall) begin
            m_st = 1;
            m_cause = hit_x ? 32'h8000_000B : 32'h8000_0007;
         end
         1: m_st = 2;
         2: if (mret_done) begin m_st = 3; m_hold = (HOLDOFF > 0) ? HOLDOFF : 1; end
         default: begin m_hold--; if (m_hold == 0) m_st = 0; end
      endcase
      m_eint = (m_st == 1);
      m_pend = m_pend & ~((bus_we && bus_addr == 3'd4) ? bus_wdata[N_EXT-1:0] : '0);
      m_pend = m_pend | (ext_irq & ~m_prev);
      m_prev = ext_irq;
      if (bus_we && bus_addr == 3'd0)      m_time = {m_time[63:32], bus_wdata};
      else if (bus_we && bus_addr == 3'd1) m_time = {bus_wdata, m_time[31:0]};
      else                                 m_time = m_time + 64'd1;
      if (bus_we && bus_addr == 3'd2) m_cmp[31:0]  = bus_wdata;
      if (bus_we && bus_addr == 3'd3) m_cmp[63:32] = bus_wdata;
      if (bus_we && bus_addr == 3'd5) begin m_en_t = bus_wdata[16]; m_en_x = bus_wdata[N_EXT-1:0]; end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      m_step();
      @(posedge clk);
      #1;
      chk("e_inter", {31'd0, e_inter}, {31'd0, m_eint});
      chk("irq_cause", irq_cause, m_cause);
      chk("bus_rdata", bus_rdata, m_rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      cyc();
      bus_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      bus_re = 1'b1; bus_addr = a;
      cyc();
      bus_re = 1'b0;
      v = bus_rdata;
   endtask

   task automatic mret();
      mret_done = 1'b1;
      cyc();
      mret_done = 1'b0;
   endtask

   task automatic wait_eint(input int lim, output int n);
      n = 0;
      while (e_inter !== 1'b1 && n < lim) begin cyc(); n++; end
      chk("wait_eint", {31'd0, e_inter}, 32'd1);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      chk("rst_e_inter", {31'd0, e_inter}, 32'd0);
      chk("rst_cause", irq_cause, 32'd0);
      chk("rst_rdata", bus_rdata, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] v;
      int n, seen;
      rst_n = 1'b0; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
      ext_irq = '0; mret_done = 1'b0; stall = 1'b0;
      m_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("reset_e_inter", {31'd0, e_inter}, 32'd0);
      chk("reset_cause", irq_cause, 32'd0);
      chk("reset_rdata", bus_rdata, 32'd0);
      rst_n = 1'b1;
      rd(3'd2, v); chk("reset_cmp_lo", v, 32'hFFFF_FFFF);
      rd(3'd5, v); chk("reset_enable", v, 32'd0);
      rd(3'd6, v); chk("reset_status", v, 32'd0);

      // timer fires at mtime==20, visible one cycle later
      wr(3'd0, 32'd0);
      wr(3'd5, 32'h1_0000);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd20);
      wait_eint(40, n);
      chk("t1_cause", irq_cause, 32'h8000_0007);
      rd(3'd0, v); chk("t1_mtime", v, 32'd21);
      rd(3'd6, v); chk("t1_status_trap", v, 32'd2);
      wr(3'd3, 32'hFFFF_FFFF);
      mret();
      idle(6);

      // ext beats a simultaneously pending timer; re-fires after hold-off
      stall = 1'b1; ext_irq = 4'b0011;
      wr(3'd5, 32'h1_0003);
      wr(3'd3, 32'd0);
      idle(1);
      rd(3'd4, v); chk("t2_pending", v, 32'h1_0003);
      stall = 1'b0;
      wait_eint(10, n);
      chk("t2_cause", irq_cause, 32'h8000_000B);
      idle(2);
      mret();
      wait_eint(10, n);
      chk("t2_refire_delay", n, 32'd3);
      wr(3'd4, 32'h3);
      wr(3'd3, 32'hFFFF_FFFF);
      idle(1);
      mret();
      ext_irq = '0;
      idle(6);

      // W1C, and edge-vs-W1C on the same cycle
      wr(3'd5, 32'd0);
      ext_irq = 4'b0001;
      idle(1);
      rd(3'd4, v); chk("t3_set", v, 32'h1);
      wr(3'd4, 32'h1);
      rd(3'd4, v); chk("t3_w1c", v, 32'h0);
      ext_irq = 4'b0000;
      idle(1);
      ext_irq = 4'b0001;
      wr(3'd4, 32'h1);
      rd(3'd4, v); chk("t3_set_wins", v, 32'h1);

      // stall holds off the fire; pulse arrives the cycle after release
      stall = 1'b1;
      seen = 0;
      wr(3'd5, 32'h1);
      if (e_inter === 1'b1) seen++;
      for (int i = 0; i < 4; i++) begin cyc(); if (e_inter === 1'b1) seen++; end
      chk("t4_no_fire_in_stall", seen, 32'd0);
      stall = 1'b0;
      cyc();
      chk("t4_fire_after_stall", {31'd0, e_inter}, 32'd1);
      wr(3'd5, 32'd0);
      wr(3'd4, 32'h1);
      mret();
      ext_irq = '0;
      idle(4);

      // wrap and direct write
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd0, 32'hFFFF_FFFF);
      rd(3'd0, v); chk("t5_all_ones_lo", v, 32'hFFFF_FFFF);
      rd(3'd1, v); chk("t5_wrap_hi", v, 32'd0);
      wr(3'd0, 32'd5);
      rd(3'd0, v); chk("t5_write_lo", v, 32'd5);
      rd(3'd7, v); chk("t5_addr7", v, 32'd0);

      // async reset while in TRAP
      wr(3'd2, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd5, 32'h1_0000);
      wait_eint(10, n);
      idle(1);
      rd(3'd6, v); chk("t6_pre_trap", v, 32'd2);
      async_reset();
      rd(3'd5, v); chk("t6_enable", v, 32'd0);
      rd(3'd2, v); chk("t6_cmp_lo", v, 32'hFFFF_FFFF);
      rd(3'd3, v); chk("t6_cmp_hi", v, 32'hFFFF_FFFF);
      rd(3'd6, v); chk("t6_status", v, 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         bus_we    = ($urandom_range(0, 7) == 0);
         bus_re    = ($urandom_range(0, 2) == 0);
         bus_addr  = 3'($urandom_range(0, 7));
         bus_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 80));
         if ($urandom_range(0, 7) == 0) ext_irq = 4'($urandom);
         mret_done = ($urandom_range(0, 11) == 0);
         stall     = ($urandom_range(0, 4) == 0);
         cyc();
      end
      bus_we = 1'b0; bus_re = 1'b0; mret_done = 1'b0; stall = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
